// File: rtl/mod_n_counter_sequencer.sv
// Run-time sequencer around a programmable mod-N counter: config handshake,
// start/pause/stop control, per-period wrap tick and budget-exhausted done pulse.
module mod_n_counter_sequencer #(
    parameter int WIDTH       = 4,
    parameter int PW          = 8,
    parameter int DEFAULT_MOD = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [PW-1:0]    cfg_periods,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [PW-1:0]    period_cnt,
    output logic             cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [WIDTH-1:0] DEF_MOD  = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] MIN_MOD  = WIDTH'(2);
    localparam logic [PW-1:0]    PCNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [PW-1:0]    period_q, period_d;
    logic [PW-1:0]    periods_q, periods_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cfg_fire;
    logic             at_wrap;
    logic [PW:0]      period_inc;

    assign cfg_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy       = (state_q == S_RUN) || (state_q == S_HOLD);
    assign count      = count_q;
    assign tick       = tick_q;
    assign done       = done_q;
    assign cfg_err    = err_q;
    assign period_cnt = period_q;

    assign cfg_fire   = cfg_valid & cfg_ready;
    // >= rather than == keeps the counter bounded even if it ever sits above mod-1
    assign at_wrap    = (count_q >= (mod_q - 1'b1));
    assign period_inc = {1'b0, period_q} + {{PW{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mod_d     = mod_q;
        period_d  = period_q;
        periods_d = periods_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (cfg_fire) begin
            if (cfg_mod >= MIN_MOD) begin
                mod_d     = cfg_mod;
                periods_d = cfg_periods;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    period_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else if (at_wrap) begin
                    count_d  = '0;
                    tick_d   = 1'b1;
                    period_d = (period_q == PCNT_MAX) ? PCNT_MAX : period_inc[PW-1:0];
                    if ((periods_q != '0) && (period_inc == {1'b0, periods_q})) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mod_q     <= DEF_MOD;
            period_q  <= '0;
            periods_q <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mod_q     <= mod_d;
            period_q  <= period_d;
            periods_q <= periods_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
